// File: rtl/core_pkg.sv
// Shared RS sizing and index/mask types for the issue select stage.
`default_nettype none

package core_pkg;
  localparam int NUM_RS_ENTRIES = 8;
  localparam int IDX_W          = $clog2(NUM_RS_ENTRIES);

  typedef logic [IDX_W-1:0]          rs_idx_t;
  typedef logic [NUM_RS_ENTRIES-1:0] rs_mask_t;
endpackage

`default_nettype wire

// File: rtl/age_matrix.sv
// NxN relative-age state for RS entries; reports the oldest requester as one-hot.
`default_nettype none

module age_matrix
  import core_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_en,
  input  logic [IDX_W-1:0] alloc_idx,
  input  logic [N-1:0]     valid_mask,
  input  logic [N-1:0]     req_mask,
  output logic [N-1:0]     oldest_oh
);

  // age_q[i][j] == 1 : entry i is older than entry j
  logic [N-1:0] age_q [N];
  logic [N-1:0] age_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      age_d[i] = age_q[i];
    end
    if (flush) begin
      for (int i = 0; i < N; i++) begin
        age_d[i] = '0;
      end
    end else if (alloc_en) begin
      // New entry is younger than everything currently valid.
      for (int i = 0; i < N; i++) begin
        if (IDX_W'(i) == alloc_idx) begin
          age_d[i] = '0;
        end else begin
          age_d[i][alloc_idx] = valid_mask[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      oldest_oh[i] = req_mask[i];
      for (int j = 0; j < N; j++) begin
        if ((j != i) && req_mask[j] && !age_q[i][j]) begin
          oldest_oh[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/issue_select.sv
// Oldest-first RS select with a valid/ready issue register, occupancy and alloc checking.
`default_nettype none

module issue_select
  import core_pkg::*;
#(
  parameter int NUM_RS_ENTRIES = core_pkg::NUM_RS_ENTRIES,
  parameter int IDX_W          = $clog2(NUM_RS_ENTRIES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_valid,
  input  logic [IDX_W-1:0]          alloc_idx,
  input  logic                      flush,
  input  logic [NUM_RS_ENTRIES-1:0] ready_vector,
  output logic [NUM_RS_ENTRIES-1:0] select_lines,
  output logic                      issue_valid,
  output logic [IDX_W-1:0]          issue_idx,
  input  logic                      issue_ready,
  output logic [IDX_W:0]            occupancy,
  output logic                      full,
  output logic                      alloc_err
);

  localparam int N     = NUM_RS_ENTRIES;
  localparam int OCC_W = IDX_W + 1;

  logic [N-1:0]     entry_valid_q, entry_valid_d;
  logic             issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0] issue_idx_q, issue_idx_d;
  logic [OCC_W-1:0] occupancy_q, occupancy_d;
  logic             full_q, full_d;
  logic             alloc_err_q, alloc_err_d;

  logic [N-1:0]     cand;
  logic [N-1:0]     oldest_oh;
  logic [N-1:0]     grant_oh;
  logic [N-1:0]     alloc_oh;
  logic [IDX_W-1:0] winner;
  logic             load;
  logic             grant;
  logic             alloc_ok;
  logic             alloc_bad;

  assign cand      = entry_valid_q & ready_vector;
  assign load      = !issue_valid_q || issue_ready;
  assign grant_oh  = (load && !flush) ? oldest_oh : '0;
  assign grant     = |grant_oh;
  assign alloc_oh  = {{(N-1){1'b0}}, 1'b1} << alloc_idx;
  assign alloc_ok  = alloc_valid && !flush && !entry_valid_q[alloc_idx];
  assign alloc_bad = alloc_valid && !flush &&  entry_valid_q[alloc_idx];

  age_matrix #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_age_matrix (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .alloc_en   (alloc_ok),
    .alloc_idx  (alloc_idx),
    .valid_mask (entry_valid_q),
    .req_mask   (cand),
    .oldest_oh  (oldest_oh)
  );

  always_comb begin
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_oh[i]) begin
        winner = winner | IDX_W'(i);
      end
    end
  end

  always_comb begin
    entry_valid_d = (entry_valid_q & ~grant_oh) | (alloc_ok ? alloc_oh : '0);
    issue_valid_d = issue_valid_q;
    issue_idx_d   = issue_idx_q;
    occupancy_d   = occupancy_q + OCC_W'(alloc_ok) - OCC_W'(grant);
    alloc_err_d   = alloc_err_q | alloc_bad;
    if (flush) begin
      entry_valid_d = '0;
      issue_valid_d = 1'b0;
      occupancy_d   = '0;
    end else if (load) begin
      issue_valid_d = grant;
      if (grant) begin
        issue_idx_d = winner;
      end
    end
    full_d = (occupancy_d == OCC_W'(N));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_valid_q <= '0;
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      occupancy_q   <= '0;
      full_q        <= 1'b0;
      alloc_err_q   <= 1'b0;
    end else begin
      entry_valid_q <= entry_valid_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      occupancy_q   <= occupancy_d;
      full_q        <= full_d;
      alloc_err_q   <= alloc_err_d;
    end
  end

  assign select_lines = grant_oh;
  assign issue_valid  = issue_valid_q;
  assign issue_idx    = issue_idx_q;
  assign occupancy    = occupancy_q;
  assign full         = full_q;
  assign alloc_err    = alloc_err_q;

endmodule

`default_nettype wire

// File: doc/issue_select.md
Name: issue_select

Overview:
- Oldest-first select stage for one functional unit's reservation stations (RS).
- Sits directly beside the dependency matrix:
  - consumes its `ready_vector`;
  - drives its `select_lines` one-hot back to it;
  - hands the chosen RS index to the FU over a valid/ready handshake.
- Tracks entry occupancy and relative age internally, with an NxN age matrix updated on allocation.

Parameters:
- `NUM_RS_ENTRIES`, 8, number of RS entries per FU (N); power of two, ≥2.
- `IDX_W`, `$clog2(NUM_RS_ENTRIES)`, width of an RS index (derived; do not override).

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-low reset.
- `alloc_valid`  in  1  an RS entry is written this cycle (dispatch).
- `alloc_idx`  in  IDX_W  index of the allocated entry; it becomes the youngest entry.
- `flush`  in  1  squash: invalidate all entries and any held issue.
- `ready_vector`  in  N  per-entry operands-ready from the dependency matrix.
- `select_lines`  out  N  one-hot of the entry granted this cycle; all-zero if none.
- `issue_valid`  out  1  issue register holds a granted entry.
- `issue_idx`  out  IDX_W  RS index held in the issue register.
- `issue_ready`  in  1  FU accepts the issue register this cycle.
- `occupancy`  out  IDX_W+1  count of valid entries.
- `full`  out  1  occupancy == N.
- `alloc_err`  out  1  sticky; set on an illegal allocation.

Behaviour:
- **Reset** (`rst`=0, async):
  - `entry_valid`, age matrix, `issue_valid`, `issue_idx`, `occupancy`, `full` and `alloc_err` all go to 0.
  - `select_lines` is 0.
- **Age matrix:** `age[i][j]`=1 means entry i is older than entry j.
  - On allocate of k at the clock edge: row k is cleared to 0; column k is set to `entry_valid` as it stands before the edge; `entry_valid[k]` is set.
- **Candidates:** `cand = entry_valid & ready_vector`.
  - Winner i is the candidate with `age[i][j]`=1 for every other candidate j.
  - The winner is unique by construction.
- **Load enable:** `load = !issue_valid || issue_ready`.
  - When `load` && `cand`≠0: `select_lines` = onehot(winner), combinational in the same cycle.
  - At the edge: `issue_idx`<=winner, `issue_valid`<=1, `entry_valid[winner]`<=0.
  - When `load` && `cand`==0: `issue_valid`<=0 at the edge.
  - When `!load`: `select_lines`=0; the issue register holds.
- **Throughput and latency:**
  - One grant per cycle; back-to-back issue is possible when `issue_ready` is held at 1.
  - Latency from ready to `issue_valid` is 1 cycle.
- **Same-cycle alloc and grant:**
  - A newly allocated entry is not a candidate until the cycle after the allocation edge.
  - Alloc of index X in the same cycle X is granted is illegal (X is still valid).
- **Illegal allocation:** `alloc_valid` to an index whose `entry_valid` is 1.
  - Sets `alloc_err` (sticky until reset).
  - The entry keeps its old age; the alloc is otherwise ignored.
- **`flush`** (highest priority):
  - At the edge: all `entry_valid`<=0, `issue_valid`<=0, age<=0.
  - `select_lines` is forced to 0 that cycle.
  - Any `alloc_valid` in that cycle is dropped.
- **Counters:**
  - `occupancy` is updated by +alloc −grant in the same cycle (net 0 when both occur).
  - `full` is a registered compare of `occupancy` against N.
- **Timing:** `ready_vector` changing while the issue register is stalled has no effect until `load`.

Decomposition:
- Shared package `CORE_PKG`:
  - `localparam NUM_RS_ENTRIES`;
  - `typedef rs_idx_t` (`logic [IDX_W-1:0]`);
  - `typedef rs_mask_t` (`logic [N-1:0]`).
- One natural sub-module: `age_matrix`.
  - Holds the NxN age state and alloc update.
  - Output: oldest-of(mask) as a one-hot.
- The top level holds the valid bits, the issue register, the handshake and the counters.

Test Plan:
1. **Age order:** alloc 3, then 5, then 1 on consecutive cycles; `ready_vector`=8'b0010_1010; `issue_ready`=1 → grants in order 3,5,1 on consecutive cycles; `select_lines` 8'h08, 8'h20, 8'h02; `occupancy` 3→0.
2. **Stall:** entries 0 and 2 ready, `issue_ready`=0 for 3 cycles → `issue_valid`=1 with `issue_idx` fixed at the older entry; `select_lines`=0 during the stall; the second grant comes one cycle after `issue_ready`=1.
3. **Younger ready first:** alloc 4 then 6; only 6 ready → 6 granted; 4 granted later when it becomes ready, i.e. age does not block a non-ready older entry.
4. **Fill and error:** alloc all 8 entries → `full`=1, `occupancy`=8; re-alloc idx 2 while valid → `alloc_err`=1 and stays 1.
5. **Flush:** `flush` with 5 valid entries and `issue_valid`=1 → next cycle `occupancy`=0, `issue_valid`=0, `select_lines`=0 even with `ready_vector`=8'hFF.
6. **Reset mid-issue:** assert `rst`=0 asynchronously mid-cycle → all outputs 0 immediately; after release, a fresh alloc 7 with ready issues 7 one cycle later.
